// File: rtl/bus_pkg.sv
// Shared types and constants for the on-chip peripheral bus and its initiator.
package bus_pkg;

  typedef logic [23:1] bus_addr_t;
  typedef logic [15:0] bus_data_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WRITE     = 3'd1,
    READ      = 3'd2,
    READ_WAIT = 3'd3,
    RESP      = 3'd4
  } init_state_t;

  localparam bus_addr_t LED_REG_ADDR = 23'h7F_FFF0;

endpackage

// File: rtl/bus_initiator.sv
// Single-outstanding bus master: one command in, one single-cycle bus strobe,
// one response out. All outputs except cmd_ready are registered.
module bus_initiator
  import bus_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  bus_addr_t   cmd_addr,
  input  bus_data_t   cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output bus_data_t   rsp_rdata,
  output bus_addr_t   address,
  output bus_data_t   bus_wdata,
  input  bus_data_t   bus_rdata,
  output logic        read_enable,
  output logic        write_enable,
  output init_state_t dbg_state
);

  // Handshakes: a beat transfers on the rising edge where valid && ready are
  // both high; the command side only accepts in IDLE, and the response is held
  // stable from rsp_valid rising until its transfer edge.

  localparam logic [2:0] CNT_LOAD = (RD_LATENCY == 0) ? 3'd0 : 3'(RD_LATENCY - 1);

  init_state_t r_state;
  init_state_t w_next_state;
  logic [2:0]  r_cnt;
  bus_addr_t   r_address;
  bus_data_t   r_wdata;
  bus_data_t   r_rdata;
  logic        r_rsp_valid;
  logic        r_re;
  logic        r_we;

  always_comb begin
    w_next_state = r_state;
    cmd_ready    = (r_state == IDLE);
    case (r_state)
      IDLE:      if (cmd_valid) w_next_state = cmd_write ? WRITE : READ;
      WRITE:     w_next_state = RESP;
      READ:      w_next_state = (RD_LATENCY == 0) ? RESP : READ_WAIT;
      READ_WAIT: if (r_cnt == 3'd0) w_next_state = RESP;
      RESP:      if (rsp_ready) w_next_state = IDLE;
      default:   w_next_state = IDLE;
    endcase
  end

  // Strobes and rsp_valid are registered copies of the next state, so each
  // is high exactly while the FSM sits in the matching state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= 3'd0;
      r_address   <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_re        <= 1'b0;
      r_we        <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_we        <= (w_next_state == WRITE);
      r_re        <= (w_next_state == READ);
      r_rsp_valid <= (w_next_state == RESP);
      case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_address <= cmd_addr;
            r_wdata   <= cmd_wdata;
          end
        end
        WRITE: r_rdata <= '0;
        READ: begin
          if (RD_LATENCY == 0) r_rdata <= bus_rdata;
          else r_cnt <= CNT_LOAD;
        end
        READ_WAIT: begin
          r_cnt <= r_cnt - 3'd1;
          if (r_cnt == 3'd0) r_rdata <= bus_rdata;
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid    = r_rsp_valid;
  assign rsp_rdata    = r_rdata;
  assign address      = r_address;
  assign bus_wdata    = r_wdata;
  assign read_enable  = r_re;
  assign write_enable = r_we;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_bus_initiator.sv
// Directed bench: four initiators (RD_LATENCY 1, 0, 3, 7), each attached to a
// register-file peripheral whose data_out is only valid in the sample cycle.
module tb_bus_initiator;
  import bus_pkg::*;

  logic        clk;
  logic        reset        [4];
  logic        cmd_valid    [4];
  logic        cmd_ready    [4];
  logic        cmd_write    [4];
  bus_addr_t   cmd_addr     [4];
  bus_data_t   cmd_wdata    [4];
  logic        rsp_valid    [4];
  logic        rsp_ready    [4];
  bus_data_t   rsp_rdata    [4];
  bus_addr_t   address      [4];
  bus_data_t   bus_wdata    [4];
  bus_data_t   bus_rdata    [4];
  logic        read_enable  [4];
  logic        write_enable [4];
  init_state_t dbg_state    [4];

  int n_total = 0;
  int n_bad   = 0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat_of(input int k);
    case (k)
      0: return 1;
      1: return 0;
      2: return 3;
      default: return 7;
    endcase
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_inst
    localparam int L = (g == 0) ? 1 : (g == 1) ? 0 : (g == 2) ? 3 : 7;
    logic [15:0] mem [256];
    logic [7:0]  re_hist;

    bus_initiator #(.RD_LATENCY(L)) u_dut (
      .clk          (clk),
      .reset        (reset[g]),
      .cmd_valid    (cmd_valid[g]),
      .cmd_ready    (cmd_ready[g]),
      .cmd_write    (cmd_write[g]),
      .cmd_addr     (cmd_addr[g]),
      .cmd_wdata    (cmd_wdata[g]),
      .rsp_valid    (rsp_valid[g]),
      .rsp_ready    (rsp_ready[g]),
      .rsp_rdata    (rsp_rdata[g]),
      .address      (address[g]),
      .bus_wdata    (bus_wdata[g]),
      .bus_rdata    (bus_rdata[g]),
      .read_enable  (read_enable[g]),
      .write_enable (write_enable[g]),
      .dbg_state    (dbg_state[g])
    );

    // Peripheral: data_out valid only L cycles after the read strobe cycle.
    always @(posedge clk) begin
      re_hist <= {re_hist[6:0], read_enable[g]};
      if (write_enable[g]) mem[address[g][8:1]] <= bus_wdata[g];
    end
    if (L == 0) begin : g_l0
      assign bus_rdata[g] = read_enable[g] ? mem[address[g][8:1]] : 16'hDEAD;
    end else begin : g_ln
      assign bus_rdata[g] = re_hist[L-1] ? mem[address[g][8:1]] : 16'hDEAD;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input int k, input string tag);
    check({tag, "_we"}, write_enable[k], 0);
    check({tag, "_re"}, read_enable[k], 0);
    check({tag, "_rsp_valid"}, rsp_valid[k], 0);
  endtask

  // One command with rsp_ready high; returns at the negedge of the response cycle.
  task automatic txn(input int k, input logic wr, input bus_addr_t a, input bus_data_t d,
                     input bus_data_t exp_rd);
    int resp_at;
    resp_at = wr ? 2 : 2 + lat_of(k);
    tick();
    cmd_valid[k] = 1'b1;
    cmd_write[k] = wr;
    cmd_addr[k]  = a;
    cmd_wdata[k] = d;
    rsp_ready[k] = 1'b1;
    @(negedge clk);
    check("idle_cmd_ready", cmd_ready[k], 1);
    check("idle_rsp_valid", rsp_valid[k], 0);
    tick();
    cmd_valid[k] = 1'b0;
    cmd_addr[k]  = '1;
    cmd_wdata[k] = '1;
    for (int c = 1; c <= resp_at; c++) begin
      if (c > 1) tick();
      @(negedge clk);
      check("we", write_enable[k], (wr && c == 1) ? 1 : 0);
      check("re", read_enable[k], (!wr && c == 1) ? 1 : 0);
      check("busy_cmd_ready", cmd_ready[k], 0);
      check("rsp_valid", rsp_valid[k], (c == resp_at) ? 1 : 0);
      if (c == 1) begin
        check("address", address[k], a);
        if (wr) check("bus_wdata", bus_wdata[k], d);
      end
      if (c == resp_at) check("rsp_rdata", rsp_rdata[k], wr ? 16'h0000 : exp_rd);
    end
  endtask

  bus_addr_t t_addr [4] = '{23'h000041, 23'h000042, 23'h000043, 23'h000044};
  bus_data_t t_data [4] = '{16'hA001, 16'h5A02, 16'h0F03, 16'hF004};

  initial begin
    for (int k = 0; k < 4; k++) begin
      reset[k] = 1'b1; cmd_valid[k] = 1'b0; cmd_write[k] = 1'b0;
      cmd_addr[k] = '0; cmd_wdata[k] = '0; rsp_ready[k] = 1'b0;
    end

    // reset held 3 cycles, then released
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        check_quiet(k, "rst");
        check("rst_cmd_ready", cmd_ready[k], 1);
        check("rst_address", address[k], 0);
        check("rst_wdata", bus_wdata[k], 0);
        check("rst_rdata", rsp_rdata[k], 0);
        check("rst_state", dbg_state[k], IDLE);
      end
    end
    tick();
    for (int k = 0; k < 4; k++) reset[k] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        check_quiet(k, "post_rst");
        check("post_rst_cmd_ready", cmd_ready[k], 1);
      end
      tick();
    end

    // write, then read with latency 1
    txn(0, 1'b1, 23'h091A2B, 16'hBEEF, 16'h0000);
    tick();
    @(negedge clk);
    check("wr_done_cmd_ready", cmd_ready[0], 1);
    check_quiet(0, "wr_done");
    txn(0, 1'b1, 23'h000010, 16'h1234, 16'h0000);
    txn(0, 1'b0, 23'h000010, 16'h0000, 16'h1234);
    txn(0, 1'b0, 23'h091A2B, 16'h0000, 16'hBEEF);

    // response backpressure while a new write is offered
    tick();
    cmd_valid[0] = 1'b1; cmd_write[0] = 1'b0; cmd_addr[0] = 23'h000010; rsp_ready[0] = 1'b0;
    tick();
    cmd_write[0] = 1'b1; cmd_addr[0] = 23'h000020; cmd_wdata[0] = 16'h5A5A;
    @(negedge clk);
    check("bp_re", read_enable[0], 1);
    check("bp_cmd_ready", cmd_ready[0], 0);
    tick();
    @(negedge clk);
    check_quiet(0, "bp_wait");
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      check("bp_rsp_valid", rsp_valid[0], 1);
      check("bp_rsp_rdata", rsp_rdata[0], 16'h1234);
      check("bp_cmd_ready", cmd_ready[0], 0);
      check("bp_we", write_enable[0], 0);
      check("bp_re", read_enable[0], 0);
    end
    tick();
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    check("bp_hs_rsp_valid", rsp_valid[0], 1);
    check("bp_hs_rsp_rdata", rsp_rdata[0], 16'h1234);
    tick();
    @(negedge clk);
    check("bp_idle_cmd_ready", cmd_ready[0], 1);
    check_quiet(0, "bp_idle");
    tick();
    cmd_valid[0] = 1'b0;
    @(negedge clk);
    check("bp_new_we", write_enable[0], 1);
    check("bp_new_address", address[0], 23'h000020);
    check("bp_new_wdata", bus_wdata[0], 16'h5A5A);
    tick();
    @(negedge clk);
    check("bp_new_rsp_valid", rsp_valid[0], 1);
    check("bp_new_rsp_rdata", rsp_rdata[0], 16'h0000);
    txn(0, 1'b0, 23'h000020, 16'h0000, 16'h5A5A);

    // reset during READ_WAIT on the latency-3 initiator
    txn(2, 1'b1, 23'h000030, 16'hC3C3, 16'h0000);
    tick();
    cmd_valid[2] = 1'b1; cmd_write[2] = 1'b0; cmd_addr[2] = 23'h000030; rsp_ready[2] = 1'b1;
    tick();
    cmd_valid[2] = 1'b0;
    tick();
    @(negedge clk);
    check("rw_state", dbg_state[2], READ_WAIT);
    #1;
    reset[2] = 1'b1;
    #1;
    check_quiet(2, "mid_rst");
    check("mid_rst_address", address[2], 0);
    check("mid_rst_wdata", bus_wdata[2], 0);
    check("mid_rst_rdata", rsp_rdata[2], 0);
    check("mid_rst_cmd_ready", cmd_ready[2], 1);
    tick();
    reset[2] = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check_quiet(2, "after_rst");
      tick();
    end
    txn(2, 1'b0, 23'h000030, 16'h0000, 16'hC3C3);

    // latency sweep with back-to-back write/read/write/read
    for (int k = 0; k < 4; k++) begin
      txn(k, 1'b1, t_addr[k], t_data[k], 16'h0000);
      txn(k, 1'b0, t_addr[k], 16'h0000, t_data[k]);
      txn(k, 1'b1, t_addr[k] + 23'h000010, ~t_data[k], 16'h0000);
      txn(k, 1'b0, t_addr[k] + 23'h000010, 16'h0000, ~t_data[k]);
      txn(k, 1'b0, t_addr[k], 16'h0000, t_data[k]);
    end

    tick();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
